rv32_run_monitor: RTL and testbench

//  Synthesizable run monitor sitting directly downstream of rv32_system_top.
//  - Consumes the SoC status outputs: flush, stall, halt and the writeback result.
//  - Counts cycles, retired writebacks, stall cycles and flush events.
//  - Folds every retired wb_result into a 32-bit signature.
//  - Ends the run on halt, or on a cycle-budget watchdog timeout.
//  - Results are read through a registered select port, both on silicon and by the self-checking bench.

---
 rtl/rv32_run_monitor_if.sv | 23 ++
 rtl/rv32_run_monitor.sv | 66 ++++++
 tb/tb_rv32_run_monitor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv32_run_monitor_if.sv
// rv32_run_monitor_if: SoC status inputs, readout select and run status outputs of the run monitor
interface rv32_run_monitor_if;
  logic        en;
  logic        clr;
  logic        flush;
  logic        stall;
  logic        halt;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        done;
  logic        timeout;
  logic        busy;
  modport master (
    output en, clr, flush, stall, halt, wb_valid, wb_result, rd_sel,
    input  rd_data, done, timeout, busy
  );
  modport slave (
    input  en, clr, flush, stall, halt, wb_valid, wb_result, rd_sel,
    output rd_data, done, timeout, busy
  );
endinterface

// File: rtl/rv32_run_monitor.sv
// rv32_run_monitor: counts run events, folds retired results into a signature, ends on halt edge or watchdog
module rv32_run_monitor #(
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 265,
  parameter logic [31:0] SIG_SEED = 32'h0
) (
  input logic               clk,
  input logic               rst_n,
  rv32_run_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10, TOUT = 2'b11} state_t;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);
  state_t           state, state_nx;
  logic             halt_q;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;
  logic [31:0]      sig;
  logic             run, halt_edge, retire, expire;
  assign run       = state == RUN;
  assign halt_edge = bus.halt & ~halt_q;
  assign retire    = run & bus.wb_valid & ~bus.stall;
  assign expire    = cyc_cnt == T_LAST;
  assign bus.done    = state == HALTED;
  assign bus.timeout = state == TOUT;
  assign bus.busy    = run;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic c);
    return (c && v != '1) ? v + 1'b1 : v;
  endfunction
  // next state: clr beats everything, halt edge beats watchdog expiry
  always_comb begin
    state_nx = state;
    if (bus.clr) state_nx = IDLE;
    else if (state == IDLE) state_nx = bus.en ? RUN : IDLE;
    else if (run) state_nx = halt_edge ? HALTED : expire ? TOUT : RUN;
  end
  // state register and halt edge detector history
  always_ff @(posedge clk) begin
    state  <= !rst_n ? IDLE : state_nx;
    halt_q <= rst_n & bus.halt;
  end
  // event counters and signature, active only while in RUN
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      sig       <= SIG_SEED;
    end else if (run) begin
      cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
      ret_cnt   <= sat_inc(ret_cnt, retire);
      stall_cnt <= sat_inc(stall_cnt, bus.stall);
      flush_cnt <= sat_inc(flush_cnt, bus.flush);
      sig       <= retire ? {sig[30:0], sig[31]} ^ bus.wb_result : sig;
    end
  end
  // registered readout of the pre-update values
  always_ff @(posedge clk) begin
    if (!rst_n) bus.rd_data <= '0;
    else bus.rd_data <= bus.rd_sel == 3'd0 ? 32'(cyc_cnt) :
                        bus.rd_sel == 3'd1 ? 32'(ret_cnt) :
                        bus.rd_sel == 3'd2 ? 32'(stall_cnt) :
                        bus.rd_sel == 3'd3 ? 32'(flush_cnt) :
                        bus.rd_sel == 3'd4 ? sig :
                        bus.rd_sel == 3'd5 ? {30'b0, state} : 32'h0;
  end
endmodule

// File: tb/tb_rv32_run_monitor.sv
// tb_rv32_run_monitor: directed checks of counters, signature, watchdog, priorities and saturation
module tb_rv32_run_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  rv32_run_monitor_if m();
  rv32_run_monitor_if m8();
  rv32_run_monitor #(.CNT_W(32), .TIMEOUT(265), .SIG_SEED(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  rv32_run_monitor #(.CNT_W(8), .TIMEOUT(255), .SIG_SEED(32'h0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8));
  always #5 clk = ~clk;
  function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31]} ^ d;
  endfunction
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input bit w8, input logic [2:0] sel, output logic [31:0] v);
    if (w8) m8.rd_sel = sel;
    else m.rd_sel = sel;
    step();
    v = w8 ? m8.rd_data : m.rd_data;
  endtask
  task automatic clear();
    m.clr = 1'b1;
    step();
    m.clr = 1'b0;
  endtask
  task automatic start();
    m.en = 1'b1;
    step();
    m.en = 1'b0;
  endtask
  logic [31:0] v, s;
  initial begin
    {m.en, m.clr, m.flush, m.stall, m.halt, m.wb_valid} = '0;
    m.wb_result = '0;
    m.rd_sel = '0;
    {m8.en, m8.clr, m8.flush, m8.stall, m8.halt, m8.wb_valid} = '0;
    m8.wb_result = '0;
    m8.rd_sel = '0;
    #1;
    m.en = 1'b1;
    m.halt = 1'b1;
    step(2);
    chk("reset_rd_data", m.rd_data, 32'h0);
    chk("reset_done", {31'b0, m.done}, 32'h0);
    chk("reset_timeout", {31'b0, m.timeout}, 32'h0);
    chk("reset_busy", {31'b0, m.busy}, 32'h0);
    rst_n = 1'b1;
    m.en = 1'b0;
    m.halt = 1'b0;
    rd(0, 3'd5, v);
    chk("reset_state", v, 32'h0);
    rd(0, 3'd4, v);
    chk("reset_sig", v, 32'h0);
    start();
    chk("run_busy", {31'b0, m.busy}, 32'h1);
    s = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      m.wb_valid = 1'b1;
      m.wb_result = 32'(i);
      m.halt = (i == 10);
      s = fold(s, 32'(i));
      step();
    end
    m.wb_valid = 1'b0;
    m.halt = 1'b0;
    chk("halt_done", {31'b0, m.done}, 32'h1);
    chk("halt_busy", {31'b0, m.busy}, 32'h0);
    rd(0, 3'd1, v);
    chk("halt_ret_cnt", v, 32'd10);
    rd(0, 3'd0, v);
    chk("halt_cyc_cnt", v, 32'd10);
    rd(0, 3'd4, v);
    chk("halt_sig", v, s);
    rd(0, 3'd5, v);
    chk("halt_state", v, 32'h2);
    clear();
    rd(0, 3'd1, v);
    chk("clr_ret_cnt", v, 32'h0);
    start();
    m.wb_valid = 1'b1;
    m.wb_result = 32'h5555_0000;
    m.stall = 1'b1;
    step(3);
    m.stall = 1'b0;
    m.wb_valid = 1'b0;
    m.flush = 1'b1;
    step(2);
    m.flush = 1'b0;
    m.wb_valid = 1'b1;
    m.wb_result = 32'h11;
    step();
    m.wb_result = 32'h8000_0001;
    m.halt = 1'b1;
    step();
    m.wb_valid = 1'b0;
    m.halt = 1'b0;
    s = fold(fold(32'h0, 32'h11), 32'h8000_0001);
    rd(0, 3'd2, v);
    chk("sf_stall_cnt", v, 32'd3);
    rd(0, 3'd3, v);
    chk("sf_flush_cnt", v, 32'd2);
    rd(0, 3'd1, v);
    chk("sf_ret_cnt", v, 32'd2);
    rd(0, 3'd0, v);
    chk("sf_cyc_cnt", v, 32'd7);
    rd(0, 3'd4, v);
    chk("sf_sig", v, s);
    rd(0, 3'd6, v);
    chk("sel6_zero", v, 32'h0);
    clear();
    start();
    step(264);
    chk("wd_busy_264", {31'b0, m.busy}, 32'h1);
    step();
    chk("wd_timeout", {31'b0, m.timeout}, 32'h1);
    chk("wd_done", {31'b0, m.done}, 32'h0);
    rd(0, 3'd0, v);
    chk("wd_cyc_cnt", v, 32'd265);
    rd(0, 3'd5, v);
    chk("wd_state", v, 32'h3);
    step(5);
    chk("wd_sticky", {31'b0, m.timeout}, 32'h1);
    clear();
    start();
    step(264);
    m.halt = 1'b1;
    step();
    chk("tie_done", {31'b0, m.done}, 32'h1);
    chk("tie_timeout", {31'b0, m.timeout}, 32'h0);
    rd(0, 3'd0, v);
    chk("tie_cyc_cnt", v, 32'd265);
    m.halt = 1'b0;
    clear();
    start();
    m.wb_valid = 1'b1;
    m.wb_result = 32'hdead_beef;
    m.stall = 1'b1;
    m.flush = 1'b1;
    step(2);
    m.stall = 1'b0;
    step();
    m.wb_valid = 1'b0;
    m.flush = 1'b0;
    m.halt = 1'b1;
    m.clr = 1'b1;
    step();
    m.clr = 1'b0;
    m.halt = 1'b0;
    chk("clrh_done", {31'b0, m.done}, 32'h0);
    chk("clrh_busy", {31'b0, m.busy}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      rd(0, 3'(i), v);
      chk($sformatf("clrh_sel%0d", i), v, 32'h0);
    end
    m8.en = 1'b1;
    step();
    m8.en = 1'b0;
    m8.stall = 1'b1;
    m8.flush = 1'b1;
    step(300);
    m8.stall = 1'b0;
    m8.flush = 1'b0;
    chk("sat_timeout", {31'b0, m8.timeout}, 32'h1);
    rd(1, 3'd0, v);
    chk("sat_cyc_cnt", v, 32'd255);
    rd(1, 3'd2, v);
    chk("sat_stall_cnt", v, 32'd255);
    rd(1, 3'd3, v);
    chk("sat_flush_cnt", v, 32'd255);
    m.halt = 1'b1;
    step();
    start();
    step(3);
    chk("lvl_busy", {31'b0, m.busy}, 32'h1);
    m.halt = 1'b0;
    step();
    chk("lvl_busy_fall", {31'b0, m.busy}, 32'h1);
    m.halt = 1'b1;
    step();
    m.halt = 1'b0;
    chk("lvl_done", {31'b0, m.done}, 32'h1);
    rd(0, 3'd0, v);
    chk("lvl_cyc_cnt", v, 32'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
